// File: rtl/mul_seq_lock.sv
// Key-locked sequential multiply unit: one multiplier bit per cycle, four product-based modes.
// Latency: WIDTH+1 cycles from the sampled ap_start edge to the ap_done cycle; one op per WIDTH+3 cycles.
// Backpressure: none; ap_start is honoured only in IDLE, and requests made while busy are dropped.
module mul_seq_lock #(
  parameter int                   WIDTH      = 32,
  parameter int                   KEY_WIDTH  = 255,
  parameter logic [KEY_WIDTH-1:0] GOLDEN_KEY = '0
) (
  input  logic                 ap_clk,
  input  logic                 ap_rst,
  input  logic                 ap_start,
  output logic                 ap_done,
  output logic                 ap_idle,
  output logic                 ap_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [WIDTH-1:0]     c,
  input  logic [1:0]           mode,
  input  logic [KEY_WIDTH-1:0] working_key,
  output logic [WIDTH-1:0]     ap_return
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [2*WIDTH-1:0]     acc_q, acc_d;
  // The multiplicand is kept pre-shifted (a << cnt) and the multiplier is shifted
  // right, so each step only looks at bit 0 instead of indexing b by cnt.
  logic [2*WIDTH-1:0]     mcand_q, mcand_d;
  logic [WIDTH-1:0]       mplier_q, mplier_d;
  logic [WIDTH-1:0]       c_q, c_d;
  logic [1:0]             mode_q, mode_d;
  logic [KEY_WIDTH-1:0]   key_q, key_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [WIDTH-1:0]       ret_q, ret_d;

  logic [WIDTH-1:0]       res_true;
  logic [WIDTH-1:0]       res_locked;

  // Mode selection on the finished product, then key-dependent corruption of the low bits.
  always_comb begin
    res_true = '0;
    case (mode_q)
      2'b00:   res_true = acc_q[WIDTH-1:0] + c_q;
      2'b01:   res_true = acc_q[WIDTH-1:0] - c_q;
      2'b10:   res_true = acc_q[WIDTH-1:0];
      default: res_true = acc_q[2*WIDTH-1:WIDTH];
    endcase
    // Only the low WIDTH key bits can perturb the result; a mismatch confined to
    // the upper key bits deliberately leaves the answer intact.
    if (key_q == GOLDEN_KEY) begin
      res_locked = res_true;
    end else begin
      res_locked = res_true ^ (key_q[WIDTH-1:0] ^ GOLDEN_KEY[WIDTH-1:0]);
    end
  end

  // Next-state and datapath update for the IDLE -> CALC -> DONE sequence.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    c_d      = c_q;
    mode_d   = mode_q;
    key_d    = key_q;
    cnt_d    = cnt_q;
    ret_d    = ret_q;
    case (state_q)
      S_IDLE: begin
        if (ap_start) begin
          mcand_d  = {{WIDTH{1'b0}}, a};
          mplier_d = b;
          c_d      = c;
          mode_d   = mode;
          key_d    = working_key;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = S_CALC;
        end
      end
      S_CALC: begin
        // One extra CALC cycle after the last bit is used to form and register the result.
        if (cnt_q == CW'(WIDTH)) begin
          ret_d   = res_locked;
          state_d = S_DONE;
        end else begin
          if (mplier_q[0]) begin
            acc_d = acc_q + mcand_q;
          end
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state_q  <= S_IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      c_q      <= '0;
      mode_q   <= '0;
      key_q    <= '0;
      cnt_q    <= '0;
      ret_q    <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      c_q      <= c_d;
      mode_q   <= mode_d;
      key_q    <= key_d;
      cnt_q    <= cnt_d;
      ret_q    <= ret_d;
    end
  end

  // Handshake outputs decode straight from the state register.
  assign ap_idle   = (state_q == S_IDLE);
  assign ap_done   = (state_q == S_DONE);
  assign ap_ready  = (state_q == S_DONE);
  assign ap_return = ret_q;

endmodule

// File: tb/tb_mul_seq_lock.sv
// Directed bench for mul_seq_lock at WIDTH=32 with a nonzero golden key.
// Hand-computed results, latency, idle/done behaviour, stability, back-to-back and reset abort.
// Inputs are driven at the falling edge; outputs are sampled at the falling edge.
module tb_mul_seq_lock;

  localparam logic [254:0] GK       = 255'h1234_5678_9ABC_DEF0_0F1E_2D3C_4B5A_6978_C001_D00D;
  localparam logic [254:0] KEY_LSB  = GK ^ 255'd1;
  localparam logic [254:0] KEY_B200 = GK ^ (255'd1 << 200);
  localparam logic [254:0] KEY_F0   = GK ^ 255'hF0;

  logic         ap_clk;
  logic         ap_rst;
  logic         ap_start;
  logic         ap_done;
  logic         ap_idle;
  logic         ap_ready;
  logic [31:0]  a;
  logic [31:0]  b;
  logic [31:0]  c;
  logic [1:0]   mode;
  logic [254:0] working_key;
  logic [31:0]  ap_return;

  int n_chk;
  int n_pass;

  mul_seq_lock #(
    .WIDTH      (32),
    .KEY_WIDTH  (255),
    .GOLDEN_KEY (GK)
  ) dut (
    .ap_clk      (ap_clk),
    .ap_rst      (ap_rst),
    .ap_start    (ap_start),
    .ap_done     (ap_done),
    .ap_idle     (ap_idle),
    .ap_ready    (ap_ready),
    .a           (a),
    .b           (b),
    .c           (c),
    .mode        (mode),
    .working_key (working_key),
    .ap_return   (ap_return)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Runs one operation. lat = number of rising edges after the sampling edge until
  // ap_done is seen (0 if it never came); idle_hi counts busy cycles with ap_idle high.
  task automatic do_op(input logic [31:0] ta, input logic [31:0] tb_, input logic [31:0] tc,
                       input logic [1:0] tm, input logic [254:0] tk, input bit scramble,
                       output logic [31:0] res, output int lat, output int idle_hi,
                       output logic rdy);
    bit seen;
    @(negedge ap_clk);
    a = ta; b = tb_; c = tc; mode = tm; working_key = tk; ap_start = 1'b1;
    @(posedge ap_clk);
    @(negedge ap_clk);
    ap_start = 1'b0;
    idle_hi = ap_idle ? 1 : 0;
    lat = 0;
    seen = 1'b0;
    res = '0;
    rdy = 1'b0;
    for (int k = 1; k <= 100 && !seen; k++) begin
      @(posedge ap_clk);
      @(negedge ap_clk);
      if (ap_done) begin
        seen = 1'b1;
        lat = k;
        res = ap_return;
        rdy = ap_ready;
      end else begin
        if (ap_idle) idle_hi++;
        if (scramble) begin
          a = $urandom; b = $urandom; c = $urandom; mode = 2'($urandom_range(3));
          working_key[31:0] = $urandom;
          ap_start = (k == 5);
        end
      end
    end
    ap_start = 1'b0;
  endtask

  logic [31:0] res;
  int          lat;
  int          idle_hi;
  logic        rdy;
  int          ndone;
  int          done_cyc[3];
  int          bad_hold;

  initial begin
    n_chk = 0; n_pass = 0;
    ap_rst = 1'b1; ap_start = 1'b0;
    a = '0; b = '0; c = '0; mode = '0; working_key = '0;
    repeat (2) @(negedge ap_clk);
    chk("rst_idle", 64'(ap_idle), 64'd1);
    chk("rst_done", 64'(ap_done), 64'd0);
    chk("rst_ready", 64'(ap_ready), 64'd0);
    chk("rst_return", 64'(ap_return), 64'd0);
    ap_rst = 1'b0;

    // Correct key, three low-half modes.
    do_op(32'd3, 32'd5, 32'd7, 2'b00, GK, 1'b0, res, lat, idle_hi, rdy);
    chk("m00_res", 64'(res), 64'd22);
    chk("m00_lat", 64'(lat), 64'd33);
    chk("m00_idle_low", 64'(idle_hi), 64'd0);
    chk("m00_ready", 64'(rdy), 64'd1);
    @(negedge ap_clk);
    chk("m00_done_1cyc", 64'(ap_done), 64'd0);
    chk("m00_back_idle", 64'(ap_idle), 64'd1);
    chk("m00_ret_hold", 64'(ap_return), 64'd22);

    do_op(32'd3, 32'd5, 32'd7, 2'b01, GK, 1'b0, res, lat, idle_hi, rdy);
    chk("m01_res", 64'(res), 64'd8);
    chk("m01_lat", 64'(lat), 64'd33);
    do_op(32'd3, 32'd5, 32'd7, 2'b10, GK, 1'b0, res, lat, idle_hi, rdy);
    chk("m10_res", 64'(res), 64'd15);
    chk("m10_idle_low", 64'(idle_hi), 64'd0);
    do_op(32'd3, 32'd5, 32'd20, 2'b01, GK, 1'b0, res, lat, idle_hi, rdy);
    chk("m01_wrap", 64'(res), 64'hFFFF_FFFB);

    // High half and wrap-around of the low half.
    do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 2'b11, GK, 1'b0, res, lat, idle_hi, rdy);
    chk("m11_high", 64'(res), 64'hFFFF_FFFE);
    do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 2'b00, GK, 1'b0, res, lat, idle_hi, rdy);
    chk("m00_wrap", 64'(res), 64'h0000_0002);
    do_op(32'd0, 32'd0, 32'd0, 2'b10, GK, 1'b0, res, lat, idle_hi, rdy);
    chk("zero_res", 64'(res), 64'd0);
    chk("zero_lat", 64'(lat), 64'd33);

    // Locking.
    do_op(32'd3, 32'd5, 32'd7, 2'b00, KEY_LSB, 1'b0, res, lat, idle_hi, rdy);
    chk("lock_lsb", 64'(res), 64'd23);
    do_op(32'd3, 32'd5, 32'd7, 2'b00, KEY_B200, 1'b0, res, lat, idle_hi, rdy);
    chk("lock_b200", 64'(res), 64'd22);
    do_op(32'd3, 32'd5, 32'd7, 2'b10, KEY_F0, 1'b0, res, lat, idle_hi, rdy);
    chk("lock_f0", 64'(res), 64'hFF);

    // Operand stability plus a stray ap_start during CALC.
    do_op(32'd3, 32'd5, 32'd7, 2'b00, GK, 1'b1, res, lat, idle_hi, rdy);
    chk("stable_res", 64'(res), 64'd22);
    chk("stable_lat", 64'(lat), 64'd33);
    ndone = 0;
    repeat (45) begin
      @(negedge ap_clk);
      if (ap_done) ndone++;
    end
    chk("stray_start_dones", 64'(ndone), 64'd0);

    // ap_start held high for three operations.
    @(negedge ap_clk);
    a = 32'd3; b = 32'd5; c = 32'd7; mode = 2'b00; working_key = GK; ap_start = 1'b1;
    ndone = 0; bad_hold = 0;
    for (int cyc = 0; cyc < 200 && ndone < 3; cyc++) begin
      @(negedge ap_clk);
      if (ap_done) begin
        done_cyc[ndone] = cyc;
        ndone++;
        if (ap_return !== 32'd22) bad_hold++;
      end else if (ndone > 0 && ap_return !== 32'd22) begin
        bad_hold++;
      end
    end
    ap_start = 1'b0;
    chk("b2b_count", 64'(ndone), 64'd3);
    chk("b2b_gap1", 64'(done_cyc[1] - done_cyc[0]), 64'd35);
    chk("b2b_gap2", 64'(done_cyc[2] - done_cyc[1]), 64'd35);
    chk("b2b_hold", 64'(bad_hold), 64'd0);

    // Reset 10 cycles into CALC.
    @(negedge ap_clk);
    @(negedge ap_clk);
    a = 32'd3; b = 32'd5; c = 32'd7; mode = 2'b00; working_key = GK; ap_start = 1'b1;
    @(posedge ap_clk);
    @(negedge ap_clk);
    ap_start = 1'b0;
    repeat (10) @(negedge ap_clk);
    chk("pre_rst_busy", 64'(ap_idle), 64'd0);
    ap_rst = 1'b1;
    #1;
    chk("arst_idle", 64'(ap_idle), 64'd1);
    chk("arst_done", 64'(ap_done), 64'd0);
    chk("arst_ready", 64'(ap_ready), 64'd0);
    chk("arst_return", 64'(ap_return), 64'd0);
    @(negedge ap_clk);
    ap_rst = 1'b0;
    ndone = 0;
    repeat (45) begin
      @(negedge ap_clk);
      if (ap_done) ndone++;
    end
    chk("abort_no_done", 64'(ndone), 64'd0);
    do_op(32'd2, 32'd9, 32'd0, 2'b10, GK, 1'b0, res, lat, idle_hi, rdy);
    chk("post_rst_res", 64'(res), 64'd18);
    chk("post_rst_lat", 64'(lat), 64'd33);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mul_seq_lock.md
# mul_seq_lock

Parametrised, multi-cycle, key-locked multiply unit with an `ap_ctrl_hs`-style start/done handshake. It computes one of four product-based functions of operands `a`, `b` and `c` using a radix-2 shift-add datapath, one multiplier bit per cycle. The result is correct only when `working_key` matches the instance's `GOLDEN_KEY`. It is the drop-in successor to the fixed 32-bit locked multiplier behind the `mul` top wrapper, adding width/key parametrisation and a mode select.

## Interface
- `WIDTH`, default 32: operand and result width; must be ≥ 2.
- `KEY_WIDTH`, default 255: locking key width; must be ≥ `WIDTH`.
- `GOLDEN_KEY`, default 0: correct unlocking key, set per instance by the integrator.
- `ap_clk`  in  1: clock; all state changes on the rising edge.
- `ap_rst`  in  1: reset, asynchronous, active-high.
- `ap_start`  in  1: request a new operation; sampled only in IDLE.
- `ap_done`  out  1: one-cycle pulse; `ap_return` is valid.
- `ap_idle`  out  1: high while in IDLE.
- `ap_ready`  out  1: one-cycle pulse, coincident with `ap_done`.
- `a`, `b`, `c`  in  `WIDTH` each: operands, unsigned.
- `mode`  in  2: operation select.
- `working_key`  in  `KEY_WIDTH`: applied unlocking key.
- `ap_return`  out  `WIDTH`: result; registered, holds its value until the next `ap_done`.

## Operation
- **Reset values:** state = IDLE, `ap_idle` = 1, `ap_done` = 0, `ap_ready` = 0, `ap_return` = 0, internal accumulator and counter = 0.
- **IDLE**
  - `ap_idle` = 1.
  - On an edge with `ap_start` = 1: latch `a`, `b`, `c`, `mode` and `working_key`, clear the 2·`WIDTH` accumulator and the bit counter, go to CALC.
- **CALC**
  - `ap_idle` = 0.
  - Each edge: if latched `b`[cnt] = 1, add (`a` << cnt) into the accumulator; then cnt++.
  - After exactly `WIDTH` iterations go to DONE, and load `ap_return` on that same edge.
- **DONE**
  - `ap_done` = `ap_ready` = 1 for exactly one cycle, `ap_idle` = 0.
  - Next edge always returns to IDLE.
- **Modes** (P = full unsigned product, 2·`WIDTH` bits):
  - 00: P[W-1:0] + c
  - 01: P[W-1:0] − c
  - 10: P[W-1:0]
  - 11: P[2W-1:W]
  - All addition and subtraction is modulo 2^`WIDTH`, with no saturation and no flags.
- **Locking**
  - If the latched key equals `GOLDEN_KEY`, `ap_return` = true result.
  - Otherwise `ap_return` = true result XOR (latched_key[W-1:0] XOR `GOLDEN_KEY`[W-1:0]).
  - A mismatch only in key bits ≥ `WIDTH` therefore still yields the correct result; this is intended.
- **Operand stability:** changes on `a`, `b`, `c`, `mode` or `working_key` during CALC or DONE have no effect.
- **`ap_start` outside IDLE:** ignored. There is no queueing.

## Timing
- **Latency:** with `ap_start` sampled at edge 0, `ap_done` is high in the cycle following edge `WIDTH`+1, i.e. 33 cycles after sampling for `WIDTH` = 32.
- **Throughput:** one operation per `WIDTH`+3 cycles when `ap_start` is held high. IDLE is visited for one cycle between operations, and the new request is sampled there.
- **`ap_done` and `ap_ready`:** decoded from registered state, glitch-free, never high for two consecutive cycles.
- **Reset mid-operation:** `ap_rst` asserted in any state immediately forces all reset values. No `ap_done` is issued for the aborted operation. After deassertion the block accepts a new `ap_start` on the first edge.
- **`b` = 0 or `a` = 0:** full latency is still taken; there is no early termination.

## Test plan
- **Correct key:** `WIDTH`=32, key = `GOLDEN_KEY`, a=3, b=5, c=7 → mode 00 returns 22, mode 01 returns 8, mode 10 returns 15. Each `ap_done` pulses exactly 33 cycles after start, and `ap_idle` is low throughout.
- **High half:** a = b = 0xFFFFFFFF, mode 11 → `ap_return` = 0xFFFFFFFE. Mode 00 with c=1 → 0x00000002, showing wrap-around.
- **Locked:** `working_key` = `GOLDEN_KEY` XOR 1, a=3, b=5, c=7, mode 00 → 23.
  - Same test with only bit 200 of the key flipped → 22.
- **Operand stability:** start with a=3, b=5, c=7, mode 00; change a, b, c and mode to random values every CALC cycle → still 22. A second `ap_start` pulse during CALC is ignored, producing exactly one `ap_done`.
- **Back-to-back and hold:** hold `ap_start` high for three operations → three `ap_done` pulses spaced 35 cycles apart. `ap_return` holds its value between pulses.
- **Reset mid-operation:** assert `ap_rst` 10 cycles into CALC → all outputs go to their reset values asynchronously and no `ap_done` follows. The next operation (a=2, b=9, c=0, mode 10) returns 18 with nominal latency.
